// File: rtl/clock_time_setter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : clock_time_setter                                             |
// | Description : Button-driven hour/minute editor for the clock core, with     |
// |               debounced buttons, RUN/SET_HR/SET_MIN/COMMIT FSM and blinking. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module clock_time_setter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [5:0] cur_hr,
    input  logic [5:0] cur_min,
    output logic [5:0] set_hr,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load,
    output logic       run_en,
    output logic       blank_hr,
    output logic       blank_min,
    output logic [1:0] mode
);

    localparam int c_DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_BKW = $clog2(BLINK_CYCLES + 1);
    localparam logic [c_DBW-1:0] c_DB_MAX  = c_DBW'(DEBOUNCE_CYCLES);
    localparam logic [c_BKW-1:0] c_BK_LAST = c_BKW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    // Bit 0 = mode, bit 1 = up, bit 2 = down
    logic [2:0] w_btn_raw;
    logic [2:0] w_press;

    assign w_btn_raw = {btn_down, btn_up, btn_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_stable;
            logic             r_stable_d;
            logic             r_press;
            logic [c_DBW-1:0] r_cnt;
            logic [c_DBW-1:0] w_cnt_inc;

            assign w_cnt_inc = r_cnt + c_DBW'(1);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_press    <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_btn_raw[gi];
                    r_sync2    <= r_sync1;
                    r_stable_d <= r_stable;
                    r_press    <= r_stable & ~r_stable_d;
                    if (r_sync2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (w_cnt_inc == c_DB_MAX) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_hr;
    logic [5:0]       r_min;
    logic [5:0]       w_hr_nxt;
    logic [5:0]       w_min_nxt;
    logic             w_blink_clr;
    logic [c_BKW-1:0] r_blink_cnt;
    logic             r_phase;
    logic             w_mode_p;
    logic             w_up_ok;
    logic             w_dn_ok;

    // Up and down cancel each other; a concurrent mode press discards the edit
    assign w_mode_p = w_press[0];
    assign w_up_ok  = w_press[1] & ~w_press[2] & ~w_press[0];
    assign w_dn_ok  = w_press[2] & ~w_press[1] & ~w_press[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_hr    <= 6'd0;
            r_min   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_hr    <= w_hr_nxt;
            r_min   <= w_min_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hr_nxt    = r_hr;
        w_min_nxt   = r_min;
        w_blink_clr = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mode_p) begin
                    w_state_nxt = ST_SET_HR;
                    w_hr_nxt    = (cur_hr  > 6'd23) ? 6'd0 : cur_hr;
                    w_min_nxt   = (cur_min > 6'd59) ? 6'd0 : cur_min;
                    w_blink_clr = 1'b1;
                end
            end
            ST_SET_HR: begin
                if (w_mode_p) begin
                    w_state_nxt = ST_SET_MIN;
                    w_blink_clr = 1'b1;
                end else if (w_up_ok) begin
                    w_hr_nxt    = (r_hr >= 6'd23) ? 6'd0 : r_hr + 6'd1;
                    w_blink_clr = 1'b1;
                end else if (w_dn_ok) begin
                    w_hr_nxt    = (r_hr == 6'd0) ? 6'd23 : r_hr - 6'd1;
                    w_blink_clr = 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (w_mode_p) begin
                    w_state_nxt = ST_COMMIT;
                end else if (w_up_ok) begin
                    w_min_nxt   = (r_min >= 6'd59) ? 6'd0 : r_min + 6'd1;
                    w_blink_clr = 1'b1;
                end else if (w_dn_ok) begin
                    w_min_nxt   = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
                    w_blink_clr = 1'b1;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Restarting the blink on every edit keeps the changed digits visible
    always_ff @(posedge clk) begin
        if (rst || w_blink_clr) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == c_BK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_BKW'(1);
        end
    end

    assign set_hr    = r_hr;
    assign set_min   = r_min;
    assign set_sec   = 6'd0;
    assign mode      = r_state;
    assign load      = (r_state == ST_COMMIT);
    assign run_en    = (r_state == ST_RUN);
    assign blank_hr  = (r_state == ST_SET_HR)  & r_phase;
    assign blank_min = (r_state == ST_SET_MIN) & r_phase;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_setter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_clock_time_setter                                          |
// | Description : Self-checking bench for clock_time_setter with a reference    |
// |               model of the editing rules and directed timing scenarios.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_clock_time_setter;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic [5:0] cur_hr   = 6'd0;
    logic [5:0] cur_min  = 6'd0;
    logic [5:0] set_hr;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       load;
    logic       run_en;
    logic       blank_hr;
    logic       blank_min;
    logic [1:0] mode;

    int n_vec = 0;
    int n_err = 0;

    int         load_cnt   = 0;
    logic [5:0] ld_hr      = 6'd0;
    logic [5:0] ld_min     = 6'd0;
    logic [5:0] ld_sec     = 6'd0;
    logic       ld_run_en  = 1'b0;
    logic       nxt_run_en = 1'b0;
    bit         after_load = 1'b0;

    // Reference model state: 0 run, 1 editing hours, 2 editing minutes
    int m_state, m_hr, m_min, m_loads, m_ld_hr, m_ld_min;

    clock_time_setter #(
        .DEBOUNCE_CYCLES (4),
        .BLINK_CYCLES    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .cur_hr    (cur_hr),
        .cur_min   (cur_min),
        .set_hr    (set_hr),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .load      (load),
        .run_en    (run_en),
        .blank_hr  (blank_hr),
        .blank_min (blank_min),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (after_load) begin
            nxt_run_en = run_en;
            after_load = 1'b0;
        end
        if (load === 1'b1) begin
            load_cnt++;
            ld_hr      = set_hr;
            ld_min     = set_min;
            ld_sec     = set_sec;
            ld_run_en  = run_en;
            after_load = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        cycles(2);
        rst = 1'b0;
        m_state = 0; m_hr = 0; m_min = 0; m_loads = 0; m_ld_hr = 0; m_ld_min = 0;
    endtask

    task automatic press(input bit m, input bit u, input bit d);
        btn_mode = m; btn_up = u; btn_down = d;
        cycles(12);
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        cycles(10);
    endtask

    task automatic model_press(input bit m, input bit u, input bit d);
        case (m_state)
            0: if (m) begin
                m_hr    = (int'(cur_hr)  > 23) ? 0 : int'(cur_hr);
                m_min   = (int'(cur_min) > 59) ? 0 : int'(cur_min);
                m_state = 1;
            end
            1: if (m) m_state = 2;
               else if (u && !d) m_hr = (m_hr + 1) % 24;
               else if (d && !u) m_hr = (m_hr + 23) % 24;
            default: if (m) begin
                m_state  = 0;
                m_loads++;
                m_ld_hr  = m_hr;
                m_ld_min = m_min;
            end else if (u && !d) m_min = (m_min + 1) % 60;
              else if (d && !u) m_min = (m_min + 59) % 60;
        endcase
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (mode !== 2'd0)     begin n_err++; $display("FAIL reset_mode: got %0d want 0", mode); end
        n_vec++; if (run_en !== 1'b1)   begin n_err++; $display("FAIL reset_run_en: got %b want 1", run_en); end
        n_vec++; if (load !== 1'b0)     begin n_err++; $display("FAIL reset_load: got %b want 0", load); end
        n_vec++; if (set_hr !== 6'd0)   begin n_err++; $display("FAIL reset_set_hr: got %0d want 0", set_hr); end
        n_vec++; if (set_min !== 6'd0)  begin n_err++; $display("FAIL reset_set_min: got %0d want 0", set_min); end
        n_vec++; if (set_sec !== 6'd0)  begin n_err++; $display("FAIL reset_set_sec: got %0d want 0", set_sec); end
        n_vec++; if ({blank_hr, blank_min} !== 2'b00)
            begin n_err++; $display("FAIL reset_blanks: got %b%b want 00", blank_hr, blank_min); end
    endtask

    task automatic test_debounce();
        do_reset();
        cur_hr = 6'd5; cur_min = 6'd10;
        btn_mode = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 7) begin
                n_vec++; if (mode !== 2'd0) begin n_err++; $display("FAIL deb_mode_early: got %0d want 0", mode); end
            end
            if (k == 8) begin
                n_vec++; if (mode !== 2'd1) begin n_err++; $display("FAIL deb_mode_latency: got %0d want 1", mode); end
                n_vec++; if (run_en !== 1'b0) begin n_err++; $display("FAIL deb_run_en_fall: got %b want 0", run_en); end
            end
        end
        btn_mode = 1'b0;
        cycles(10);
        btn_up = 1'b1;
        cycles(3);
        btn_up = 1'b0;
        cycles(15);
        n_vec++; if (set_hr !== 6'd5) begin n_err++; $display("FAIL deb_glitch: got %0d want 5", set_hr); end
        btn_up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 7) begin
                n_vec++; if (set_hr !== 6'd5) begin n_err++; $display("FAIL deb_up_early: got %0d want 5", set_hr); end
            end
            if (k == 8) begin
                n_vec++; if (set_hr !== 6'd6) begin n_err++; $display("FAIL deb_up_latency: got %0d want 6", set_hr); end
            end
        end
        btn_up = 1'b0;
        cycles(10);
        n_vec++; if (set_hr !== 6'd6) begin n_err++; $display("FAIL deb_held_once: got %0d want 6", set_hr); end
    endtask

    task automatic test_full_edit();
        int l0;
        do_reset();
        cur_hr = 6'd22; cur_min = 6'd58;
        l0 = load_cnt;
        press(1, 0, 0);
        n_vec++; if ({set_hr, set_min} !== {6'd22, 6'd58})
            begin n_err++; $display("FAIL full_capture: got %0d:%0d want 22:58", set_hr, set_min); end
        press(0, 1, 0); press(0, 1, 0); press(1, 0, 0);
        press(0, 1, 0); press(0, 1, 0);
        n_vec++; if (load_cnt !== l0) begin n_err++; $display("FAIL full_early_load: got %0d want %0d", load_cnt, l0); end
        press(1, 0, 0);
        n_vec++; if (load_cnt !== l0 + 1) begin n_err++; $display("FAIL full_load_count: got %0d want %0d", load_cnt, l0 + 1); end
        n_vec++; if ({ld_hr, ld_min, ld_sec} !== 18'd0)
            begin n_err++; $display("FAIL full_load_value: got %0d:%0d:%0d want 0:0:0", ld_hr, ld_min, ld_sec); end
        n_vec++; if (ld_run_en !== 1'b0) begin n_err++; $display("FAIL full_run_en_commit: got %b want 0", ld_run_en); end
        n_vec++; if (nxt_run_en !== 1'b1) begin n_err++; $display("FAIL full_run_en_after: got %b want 1", nxt_run_en); end
        n_vec++; if (mode !== 2'd0) begin n_err++; $display("FAIL full_mode_end: got %0d want 0", mode); end
    endtask

    task automatic test_down_wrap();
        int l0;
        do_reset();
        cur_hr = 6'd0; cur_min = 6'd0;
        l0 = load_cnt;
        press(1, 0, 0); press(0, 0, 1); press(1, 0, 0); press(0, 0, 1); press(1, 0, 0);
        n_vec++; if (load_cnt !== l0 + 1) begin n_err++; $display("FAIL wrap_load_count: got %0d want %0d", load_cnt, l0 + 1); end
        n_vec++; if ({ld_hr, ld_min} !== {6'd23, 6'd59})
            begin n_err++; $display("FAIL wrap_load_value: got %0d:%0d want 23:59", ld_hr, ld_min); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cur_hr = 6'd5; cur_min = 6'd30;
        press(1, 0, 0);
        press(0, 1, 1);
        n_vec++; if (set_hr !== 6'd5) begin n_err++; $display("FAIL simul_updown: got %0d want 5", set_hr); end
        n_vec++; if (mode !== 2'd1) begin n_err++; $display("FAIL simul_updown_mode: got %0d want 1", mode); end
        press(1, 1, 0);
        n_vec++; if (mode !== 2'd2) begin n_err++; $display("FAIL simul_mode_up: got %0d want 2", mode); end
        n_vec++; if (set_hr !== 6'd5) begin n_err++; $display("FAIL simul_mode_up_hr: got %0d want 5", set_hr); end
        press(1, 0, 0);
        n_vec++; if ({ld_hr, ld_min} !== {6'd5, 6'd30})
            begin n_err++; $display("FAIL simul_load_value: got %0d:%0d want 5:30", ld_hr, ld_min); end
    endtask

    task automatic test_blink();
        bit seen;
        do_reset();
        cur_hr = 6'd3; cur_min = 6'd4;
        btn_mode = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            n_vec++;
            if (blank_hr !== ((k >= 8) ? 1'(((k - 8) / 8) % 2) : 1'b0))
                begin n_err++; $display("FAIL blink_hr k=%0d: got %b", k, blank_hr); end
            n_vec++; if (blank_min !== 1'b0) begin n_err++; $display("FAIL blink_min k=%0d: got %b want 0", k, blank_min); end
        end
        btn_mode = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (blank_hr === 1'b1) seen = 1'b1;
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL blink_rise_timeout: got none want rise within 20"); end
        cycles(4);
        btn_up = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            step();
            if (k >= 8) begin
                n_vec++;
                if (blank_hr !== ((k >= 16) ? 1'b1 : 1'b0))
                    begin n_err++; $display("FAIL blink_restart k=%0d: got %b", k, blank_hr); end
            end
        end
        btn_up = 1'b0;
        cycles(10);
        n_vec++; if (set_hr !== 6'd4) begin n_err++; $display("FAIL blink_up_hr: got %0d want 4", set_hr); end
        press(1, 0, 0); press(1, 0, 0);
        for (int k = 0; k < 30; k++) begin
            step();
            n_vec++; if ({blank_hr, blank_min} !== 2'b00)
                begin n_err++; $display("FAIL blink_run k=%0d: got %b%b want 00", k, blank_hr, blank_min); end
        end
    endtask

    task automatic test_reset_mid_edit();
        int l0;
        do_reset();
        cur_hr = 6'd7; cur_min = 6'd8;
        press(1, 0, 0); press(1, 0, 0);
        n_vec++; if (mode !== 2'd2) begin n_err++; $display("FAIL midrst_pre_mode: got %0d want 2", mode); end
        l0 = load_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++; if (mode !== 2'd0) begin n_err++; $display("FAIL midrst_mode: got %0d want 0", mode); end
        n_vec++; if (set_hr !== 6'd0) begin n_err++; $display("FAIL midrst_set_hr: got %0d want 0", set_hr); end
        cycles(20);
        n_vec++; if (load_cnt !== l0) begin n_err++; $display("FAIL midrst_no_load: got %0d want %0d", load_cnt, l0); end
        n_vec++; if (run_en !== 1'b1) begin n_err++; $display("FAIL midrst_run_en: got %b want 1", run_en); end
    endtask

    task automatic test_random();
        int  base;
        int  sel;
        bit  m, u, d;
        do_reset();
        base = load_cnt;
        for (int it = 0; it < 60; it++) begin
            sel = int'($urandom_range(0, 5));
            m = (sel == 0) || (sel == 1) || (sel == 5);
            u = (sel == 2) || (sel == 4) || (sel == 5);
            d = (sel == 3) || (sel == 4);
            cur_hr  = 6'($urandom_range(0, 40));
            cur_min = 6'($urandom_range(0, 63));
            press(m, u, d);
            model_press(m, u, d);
            n_vec++; if (mode !== 2'(m_state))
                begin n_err++; $display("FAIL rand_mode it=%0d: got %0d want %0d", it, mode, m_state); end
            n_vec++; if ({set_hr, set_min} !== {6'(m_hr), 6'(m_min)})
                begin n_err++; $display("FAIL rand_edit it=%0d: got %0d:%0d want %0d:%0d", it, set_hr, set_min, m_hr, m_min); end
            n_vec++; if (run_en !== (m_state == 0))
                begin n_err++; $display("FAIL rand_run_en it=%0d: got %b want %b", it, run_en, m_state == 0); end
            n_vec++; if (load_cnt - base !== m_loads)
                begin n_err++; $display("FAIL rand_loads it=%0d: got %0d want %0d", it, load_cnt - base, m_loads); end
            if (m_loads > 0) begin
                n_vec++; if ({ld_hr, ld_min} !== {6'(m_ld_hr), 6'(m_ld_min)})
                    begin n_err++; $display("FAIL rand_load_val it=%0d: got %0d:%0d want %0d:%0d", it, ld_hr, ld_min, m_ld_hr, m_ld_min); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_full_edit();
        test_down_wrap();
        test_simultaneous();
        test_blink();
        test_reset_mid_edit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
